// File: rtl/counter_share_arb_pkg.sv
// Shared FSM encoding and legal parameter ranges for counter_share_arb.
package counter_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;
    localparam int CNT_W_MIN   = 1;
    localparam int CNT_W_MAX   = 16;

    // Width of a requester index / round-robin pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_share_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
    import counter_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_share_arb.sv
// Round-robin owner sequencing of one shared tick counter.
// Optional macro COUNTER_SHARE_ARB_LOCK_EN adds a lock input that lets the
// owner chain a new run straight out of DONE without releasing the counter.
module counter_share_arb
    import counter_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    input  logic                     tick_en,
`ifdef COUNTER_SHARE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic [NUM_REQ-1:0]       done,
    output logic                     overflow
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
        $error("counter_share_arb: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     len_q, len_d;

    logic [CNT_W-1:0]     len_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   win;
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic                 own_req;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = len[i*CNT_W +: CNT_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_vld)
    );

    // One-hot winner to index, used for length select and pointer advance.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win[i]) win_idx = PTR_W'(i);
    end

    assign own_req = |(req & grant_q);

    // Next-state: arbitration in IDLE, tick counting in RUN, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                count_d = '0;
                if (win_vld) begin
                    state_d = ST_RUN;
                    grant_d = win;
                    owner_d = win_idx;
                    len_d   = len_arr[win_idx];
                    ptr_d   = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_RUN: begin
                // Abort beats a coincident final tick.
                if (!own_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    count_d = '0;
                end else if (tick_en) begin
                    count_d = count_q + 1'b1;
                    if (count_q == len_q - 1'b1)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                count_d = '0;
`ifdef COUNTER_SHARE_ARB_LOCK_EN
                // Owner keeps the counter; pointer was already advanced at grant.
                if (own_req && |(lock & grant_q)) begin
                    state_d = ST_RUN;
                    grant_d = grant_q;
                    len_d   = len_arr[owner_q];
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign count    = count_q;
    assign done     = (state_q == ST_DONE) ? grant_q : '0;
    assign overflow = (state_q == ST_RUN) && (&count_q) && tick_en;

endmodule

// File: tb/tb_counter_share_arb.sv
// Bench for counter_share_arb: directed literal checks plus random traffic
// compared every cycle against a run-level model (owner, ticks done, length).
module tb_counter_share_arb;

    localparam int N = 4;
    localparam int W = 4;
    localparam int FULL = 1 << W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic           tick_en = 1'b0;
    logic [N-1:0]   lock = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;
    logic           overflow;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    counter_share_arb #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .len      (len),
        .tick_en  (tick_en),
`ifdef COUNTER_SHARE_ARB_LOCK_EN
        .lock     (lock),
`endif
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Run-level model: who owns the counter, ticks consumed, run length.
    int m_owner = -1;
    int m_ticks = 0;
    int m_len   = 1;
    int m_ptr   = 0;
    bit m_done  = 1'b0;

    initial begin
        int c, lv;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1; m_ticks = 0; m_ptr = 0; m_done = 1'b0;
            end else if (m_owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (m_owner < 0 && req[c]) begin
                        m_owner = c;
                        lv      = int'(len[c*W +: W]);
                        m_len   = (lv == 0) ? FULL : lv;
                        m_ticks = 0;
                        m_ptr   = (c + 1) % N;
                    end
                end
            end else if (m_done) begin
                m_done  = 1'b0;
                m_owner = -1;
                m_ticks = 0;
            end else if (!req[m_owner]) begin
                m_owner = -1;
                m_ticks = 0;
            end else if (tick_en) begin
                m_ticks++;
                if (m_ticks == m_len) m_done = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        int eg, ed, ec, eo;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                eg = (m_owner >= 0) ? (1 << m_owner) : 0;
                ed = m_done ? eg : 0;
                ec = m_ticks % FULL;
                eo = (m_owner >= 0 && !m_done && ec == FULL-1 && tick_en) ? 1 : 0;
                chk("m_grant", 32'(grant), 32'(eg));
                chk("m_done", 32'(done), 32'(ed));
                chk("m_count", 32'(count), 32'(ec));
                chk("m_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
                chk("m_overflow", 32'(overflow), 32'(eo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int en_cnt;
        bit got;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk_on = 1'b1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;

        // Single run of length 3
        req = 4'b0001; len[0 +: W] = 4'd3; tick_en = 1'b1;
        tick(); chk("s1_grant", 32'(grant), 1); chk("s1_c0", 32'(count), 0);
        tick(); chk("s1_c1", 32'(count), 1);
        tick(); chk("s1_c2", 32'(count), 2); chk("s1_nodone", 32'(done), 0);
        tick(); chk("s1_done", 32'(done), 1); chk("s1_grant_hold", 32'(grant), 1);
        req = '0;
        tick(); chk("s1_release", 32'(grant), 0); chk("s1_done_off", 32'(done), 0);

        // All requesting, length 1: rotation 0,1,2,3,0
        do_reset();
        req = 4'b1111; len = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            tick(); chk("s2_grant", 32'(grant), 32'(1 << (k % 4)));
            tick(); chk("s2_done", 32'(done), 32'(1 << (k % 4)));
            tick(); chk("s2_idle", 32'(grant), 0);
        end
        req = '0; tick();

        // Full-length run (len 0 = 16 ticks)
        do_reset();
        req = 4'b0001; len = '0; tick_en = 1'b1;
        tick(); chk("s3_grant", 32'(grant), 1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 14) chk("s3_ovf14", 32'(overflow), 0);
        end
        chk("s3_c15", 32'(count), 15);
        chk("s3_ovf15", 32'(overflow), 1);
        tick(); chk("s3_done", 32'(done), 1); chk("s3_wrap", 32'(count), 0);
        req = '0; tick();

        // tick_en toggling, len1=5
        do_reset();
        req = 4'b0010; len[W +: W] = 4'd5;
        tick(); chk("s4_grant", 32'(grant), 2);
        en_cnt = 0; got = 1'b0;
        for (int g = 0; g < 40 && !got; g++) begin
            tick_en = (g % 2 == 0);
            tick();
            if (tick_en) en_cnt++;
            chk("s4_count", 32'(count), 32'(en_cnt));
            if (done[1]) got = 1'b1;
        end
        chk("s4_got_done", 32'(got), 1);
        chk("s4_ticks", 32'(en_cnt), 5);
        req = '0; tick_en = 1'b1; tick();

        // Abort of requester 2 at count 2; arbitration resumes at 3
        do_reset();
        req = 4'b0100; len = 16'h1600;
        tick(); chk("s5_grant", 32'(grant), 4);
        tick(); tick(); chk("s5_c2", 32'(count), 2);
        req = 4'b1001;
        tick(); chk("s5_abort", 32'(grant), 0); chk("s5_nodone", 32'(done), 0);
        tick(); chk("s5_next", 32'(grant), 8);
        req = '0; tick(); tick();

        // Reset mid-run at count 7; pointer returns to 0
        do_reset();
        req = 4'b0010; len = 16'h00A0;
        tick(); chk("s6_grant", 32'(grant), 2);
        for (int i = 0; i < 7; i++) tick();
        chk("s6_c7", 32'(count), 7);
        rst = 1'b1;
        tick(); chk("s6_rgrant", 32'(grant), 0); chk("s6_rcount", 32'(count), 0);
        chk("s6_rbusy", 32'(busy), 0);
        rst = 1'b0; req = 4'b1110; len = 16'h1111;
        tick(); chk("s6_ptr0", 32'(grant), 2);
        req = '0; tick(); tick();

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) len = (N*W)'($urandom);
            tick_en = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
